// File: rtl/bitvec_encoder.sv
// Sequential priority encoder: accepts a bit vector and emits the index of each
// set bit, one per handshake, in LSB-first or MSB-first order.
module bitvec_encoder #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned IDX_W     = 5,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] opcode,
  output logic             out_last,
  output logic [IDX_W:0]   pending_cnt,
  output logic             zero_vec
);

  localparam int unsigned CW = IDX_W + 1;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] pending;
  logic [IDX_W-1:0] pick;
  logic [CW-1:0]    in_cnt;
  logic             single;
  logic             accept;
  logic             retire;

  // Priority pick over the remaining bits; later loop hits override earlier ones.
  always_comb begin
    pick = '0;
    if (LSB_FIRST) begin
      for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
        if (pending[i]) pick = IDX_W'(i);
      end
    end else begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (pending[i]) pick = IDX_W'(i);
      end
    end
  end

  always_comb begin
    in_cnt = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      in_cnt = in_cnt + CW'(in_vec[i]);
    end
  end

  assign single    = (pending != '0) && ((pending & (pending - WIDTH'(1))) == '0);
  assign in_ready  = rst_n && enable && (state == IDLE);
  assign out_valid = rst_n && enable && (state == SCAN);
  assign opcode    = (state == SCAN) ? pick : '0;
  assign out_last  = (state == SCAN) && single;
  assign accept    = in_valid && in_ready;
  assign retire    = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      pending     <= '0;
      pending_cnt <= '0;
      zero_vec    <= 1'b0;
    end else begin
      // An all-zero vector is consumed in place and only reported by the pulse.
      zero_vec <= accept && (in_vec == '0);
      if (state == IDLE) begin
        if (accept && (in_vec != '0)) begin
          pending     <= in_vec;
          pending_cnt <= in_cnt;
          state       <= SCAN;
        end
      end else begin
        if (retire) begin
          pending     <= pending & ~(WIDTH'(1) << pick);
          pending_cnt <= pending_cnt - CW'(1);
          if (single) state <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_bitvec_encoder.sv
// Bench for bitvec_encoder: LSB-first and MSB-first instances share stimulus and
// are checked every cycle against a queue-based model, plus directed literal checks.
module tb_bitvec_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_vec;

  logic        l_in_ready, l_out_valid, l_out_last, l_zero_vec;
  logic [4:0]  l_opcode;
  logic [5:0]  l_cnt;
  logic        m_in_ready, m_out_valid, m_out_last, m_zero_vec;
  logic [4:0]  m_opcode;
  logic [5:0]  m_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bitvec_encoder #(.WIDTH(32), .IDX_W(5), .LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid),
    .in_ready(l_in_ready), .in_vec(in_vec), .out_valid(l_out_valid),
    .out_ready(out_ready), .opcode(l_opcode), .out_last(l_out_last),
    .pending_cnt(l_cnt), .zero_vec(l_zero_vec)
  );

  bitvec_encoder #(.WIDTH(32), .IDX_W(5), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid),
    .in_ready(m_in_ready), .in_vec(in_vec), .out_valid(m_out_valid),
    .out_ready(out_ready), .opcode(m_opcode), .out_last(m_out_last),
    .pending_cnt(m_cnt), .zero_vec(m_zero_vec)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the remaining indices of the current vector, in emission order.
  int q_l[$];
  int q_m[$];
  bit m_zero  = 1'b0;
  bit started = 1'b0;

  always @(posedge clk) begin
    bit busy, rdy, vld;
    busy = q_l.size() > 0;
    rdy  = rst_n && enable && !busy;
    vld  = rst_n && enable && busy;
    if (!rst_n) begin
      q_l.delete();
      q_m.delete();
      m_zero  = 1'b0;
      started = 1'b1;
    end else begin
      m_zero = rdy && in_valid && (in_vec == 32'd0);
      if (rdy && in_valid && (in_vec != 32'd0)) begin
        for (int b = 0; b < 32; b++) begin
          if (in_vec[b]) begin
            q_l.push_back(b);
            q_m.push_front(b);
          end
        end
      end else if (vld && out_ready) begin
        void'(q_l.pop_front());
        void'(q_m.pop_front());
      end
    end
  end

  task automatic cmp_inst(input string tag, input logic ir, input logic ov,
                          input logic [4:0] op, input logic last, input logic [5:0] cnt,
                          input logic zv, input int head, input int size);
    bit busy;
    busy = size > 0;
    chk({tag, " in_ready"},    32'(ir),   32'(rst_n && enable && !busy));
    chk({tag, " out_valid"},   32'(ov),   32'(rst_n && enable && busy));
    chk({tag, " opcode"},      32'(op),   busy ? 32'(head) : 32'd0);
    chk({tag, " out_last"},    32'(last), 32'(busy && (size == 1)));
    chk({tag, " pending_cnt"}, 32'(cnt),  32'(size));
    chk({tag, " zero_vec"},    32'(zv),   32'(m_zero));
  endtask

  always @(negedge clk) begin
    if (started) begin
      cmp_inst("lsb", l_in_ready, l_out_valid, l_opcode, l_out_last, l_cnt, l_zero_vec,
               (q_l.size() > 0) ? q_l[0] : 0, q_l.size());
      cmp_inst("msb", m_in_ready, m_out_valid, m_opcode, m_out_last, m_cnt, m_zero_vec,
               (q_m.size() > 0) ? q_m[0] : 0, q_m.size());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic probe();
    #1;
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while (!(l_in_ready === 1'b1) && n < limit) begin
      step();
      probe();
      n++;
    end
    chk("drain timeout", 32'(n < limit), 32'd1);
  endtask

  int el[4] = '{0, 5, 10, 31};
  int em[4] = '{31, 10, 5, 0};

  initial begin
    logic [31:0] acc_l, acc_m;
    int ret_l, cyc, mode;

    rst_n = 1'b0; enable = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_vec = 32'd0;
    repeat (3) step();
    probe();
    chk("rst out_valid", 32'(l_out_valid), 32'd0);
    chk("rst in_ready",  32'(l_in_ready),  32'd0);
    chk("rst opcode",    32'(l_opcode),    32'd0);
    chk("rst cnt",       32'(l_cnt),       32'd0);
    chk("rst zero_vec",  32'(l_zero_vec),  32'd0);

    // Single bit
    rst_n = 1'b1; in_valid = 1'b1; in_vec = 32'h0000_0001;
    probe();
    chk("t1 in_ready", 32'(l_in_ready), 32'd1);
    step(); in_valid = 1'b0; probe();
    chk("t1 out_valid", 32'(l_out_valid), 32'd1);
    chk("t1 opcode",    32'(l_opcode),    32'd0);
    chk("t1 last",      32'(l_out_last),  32'd1);
    chk("t1 cnt",       32'(l_cnt),       32'd1);
    step(); probe();
    chk("t1 in_ready after", 32'(l_in_ready), 32'd1);

    // Sparse vector, both orders
    in_valid = 1'b1; in_vec = 32'h8000_0421;
    step(); in_valid = 1'b0; probe();
    for (int i = 0; i < 4; i++) begin
      chk("t2 lsb opcode", 32'(l_opcode),   32'(el[i]));
      chk("t2 msb opcode", 32'(m_opcode),   32'(em[i]));
      chk("t2 cnt",        32'(l_cnt),      32'(4 - i));
      chk("t2 last",       32'(l_out_last), 32'(i == 3));
      step(); probe();
    end
    chk("t2 in_ready", 32'(l_in_ready), 32'd1);

    // Full vector with alternating backpressure
    in_valid = 1'b1; in_vec = 32'hFFFF_FFFF;
    step(); in_valid = 1'b0; probe();
    chk("t3 cnt start", 32'(l_cnt), 32'd32);
    acc_l = 32'd0; acc_m = 32'd0; ret_l = 0; cyc = 0;
    while (!(l_in_ready === 1'b1) && cyc < 200) begin
      out_ready = ((cyc % 2) == 0);
      probe();
      if (l_out_valid && out_ready) begin
        acc_l |= 32'd1 << l_opcode;
        ret_l++;
      end
      if (m_out_valid && out_ready) acc_m |= 32'd1 << m_opcode;
      step();
      cyc++;
    end
    out_ready = 1'b1;
    probe();
    chk("t3 lsb or",   acc_l,        32'hFFFF_FFFF);
    chk("t3 msb or",   acc_m,        32'hFFFF_FFFF);
    chk("t3 retires",  32'(ret_l),   32'd32);
    chk("t3 in_ready", 32'(l_in_ready), 32'd1);

    // All-zero vector
    in_valid = 1'b1; in_vec = 32'd0;
    step(); in_valid = 1'b0; probe();
    chk("t4 zero_vec",  32'(l_zero_vec),  32'd1);
    chk("t4 out_valid", 32'(l_out_valid), 32'd0);
    chk("t4 in_ready",  32'(l_in_ready),  32'd1);
    step(); probe();
    chk("t4 zero_vec end", 32'(l_zero_vec), 32'd0);

    // Enable drop mid-scan
    in_valid = 1'b1; in_vec = 32'h0000_00F0;
    step(); in_valid = 1'b0; probe();
    chk("t5 opcode 4", 32'(l_opcode), 32'd4);
    step(); probe();
    chk("t5 opcode 5", 32'(l_opcode), 32'd5);
    step(); enable = 1'b0; probe();
    chk("t5 frozen out_valid", 32'(l_out_valid), 32'd0);
    chk("t5 frozen in_ready",  32'(l_in_ready),  32'd0);
    repeat (3) step();
    probe();
    chk("t5 frozen cnt", 32'(l_cnt), 32'd2);
    enable = 1'b1; probe();
    chk("t5 resume out_valid", 32'(l_out_valid), 32'd1);
    chk("t5 resume opcode",    32'(l_opcode),    32'd6);
    chk("t5 resume cnt",       32'(l_cnt),       32'd2);
    drain(50);

    // Reset mid-sequence
    in_valid = 1'b1; in_vec = 32'h0000_0F00;
    step(); in_valid = 1'b0; probe();
    chk("t6 opcode 8", 32'(l_opcode), 32'd8);
    step(); probe();
    chk("t6 opcode 9", 32'(l_opcode), 32'd9);
    step(); rst_n = 1'b0;
    step(); rst_n = 1'b1; probe();
    chk("t6 out_valid", 32'(l_out_valid), 32'd0);
    chk("t6 cnt",       32'(l_cnt),       32'd0);
    chk("t6 opcode",    32'(l_opcode),    32'd0);
    in_valid = 1'b1; in_vec = 32'h0000_0002;
    step(); in_valid = 1'b0; probe();
    chk("t6 new opcode lsb", 32'(l_opcode), 32'd1);
    chk("t6 new opcode msb", 32'(m_opcode), 32'd1);
    drain(50);

    // Random traffic checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      step();
      rst_n     = ($urandom_range(0, 149) != 0);
      enable    = ($urandom_range(0, 9) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = $urandom_range(0, 1) == 1;
      mode      = int'($urandom_range(0, 5));
      case (mode)
        0:       in_vec = 32'd0;
        1:       in_vec = 32'hFFFF_FFFF;
        2:       in_vec = $urandom;
        3:       in_vec = $urandom & $urandom & $urandom;
        4:       in_vec = 32'd1 << $urandom_range(0, 31);
        default: in_vec = $urandom & $urandom;
      endcase
    end
    step();
    rst_n = 1'b1; enable = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    drain(100);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
